bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Sits between the 32-bit event counter and the per-digit seven-segment decoders.
- Converts a captured snapshot of the count value. Holds the last result stable so the display never shows a half-converted value.
- Start/busy/done handshake lets the control state machine request a refresh, e.g. once per divided clock tick.

---
 rtl/bin2bcd_seq_if.sv | 25 ++
 rtl/bin2bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle for bin2bcd_seq.
//   master : drives START (conversion request) and BIN (binary value); sees the results.
//   slave  : the converter; drives BUSY, DONE (one-cycle result pulse),
//            BCD (4*DIGITS bits, digit 0 in [3:0]) and OVF (result exceeded 10^DIGITS-1).
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 26,
  parameter int unsigned DIGITS = 8
);
  logic                  START;
  logic [BIN_W-1:0]      BIN;
  logic                  BUSY;
  logic                  DONE;
  logic [4*DIGITS-1:0]   BCD;
  logic                  OVF;

  modport master (
    output START, BIN,
    input  BUSY, DONE, BCD, OVF
  );

  modport slave (
    input  START, BIN,
    output BUSY, DONE, BCD, OVF
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble, one bit per cycle).
// A START seen in IDLE snapshots BIN; BIN_W shift cycles later the FINISH state writes
// BCD/OVF and DONE pulses for one cycle. BCD/OVF hold their value between results so the
// display never shows a half-converted number.
//
// Ports:
//   CLK  : clock, rising edge.
//   RSET : synchronous active-high reset; aborts any conversion in flight.
//   bus  : bin2bcd_seq_if.slave -- START/BIN in, BUSY/DONE/BCD/OVF out.
//
// Parameters: BIN_W (1..32) input width, DIGITS (1..10) output digits.
//
// Optional build macro BIN2BCD_LZB_EN: leading-zero blanking. When defined, digits above
// the most significant non-zero digit are written as 4'hF (decoder shows blank). Digit 0
// is never blanked and an overflowed result is never blanked.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 26,
  parameter int unsigned DIGITS = 8
) (
  input  logic         CLK,
  input  logic         RSET,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_scratch;
  logic             r_ovf_flag;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;
  logic             r_done;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_scratch_nxt;
  logic [BIN_W-1:0] w_shift_nxt;
  logic             w_carry;
  logic [BCD_W-1:0] w_result;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is a carry worth 10^DIGITS; dropping it leaves the
  // result modulo 10^DIGITS, and it is remembered as overflow.
  assign w_carry       = w_adj[BCD_W-1];
  assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_shift_nxt   = r_shift << 1;

`ifdef BIN2BCD_LZB_EN
  logic w_lead;

  always_comb begin
    w_result = r_scratch;
    w_lead   = ~r_ovf_flag;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (r_scratch[4*k +: 4] != 4'd0) begin
        w_lead = 1'b0;
      end
      if (w_lead) begin
        w_result[4*k +: 4] = 4'hF;
      end
    end
  end
`else
  assign w_result = r_scratch;
`endif

  always_ff @(posedge CLK) begin
    if (RSET) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_ovf_flag <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_shift    <= bus.BIN;
            r_scratch  <= '0;
            r_ovf_flag <= 1'b0;
            r_cnt      <= CNT_W'(BIN_W);
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift    <= w_shift_nxt;
          r_scratch  <= w_scratch_nxt;
          r_ovf_flag <= r_ovf_flag | w_carry;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_bcd   <= w_result;
          r_ovf   <= r_ovf_flag;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY = (r_state != S_IDLE);
  assign bus.DONE = r_done;
  assign bus.BCD  = r_bcd;
  assign bus.OVF  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an 8-digit and a 4-digit instance (both 26-bit input).
// Stimulus pushes the hand-computed result and the expected DONE cycle into a queue;
// a negedge monitor pops and compares each time DONE is seen.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(26), .DIGITS(8)) bus8 ();
  bin2bcd_seq_if #(.BIN_W(26), .DIGITS(4)) bus4 ();

  bin2bcd_seq #(.BIN_W(26), .DIGITS(8)) u_dut8 (
    .CLK  (clk),
    .RSET (rst),
    .bus  (bus8)
  );

  bin2bcd_seq #(.BIN_W(26), .DIGITS(4)) u_dut4 (
    .CLK  (clk),
    .RSET (rst),
    .bus  (bus4)
  );

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   done8     = 0;
  int   done4     = 0;
  logic prev_done8 = 1'b0;
  logic prev_done4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] sel(input logic [31:0] plain, input logic [31:0] lzb);
`ifdef BIN2BCD_LZB_EN
    return lzb;
`else
    return plain;
`endif
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.DONE) begin
        check("done8_width", 64'(prev_done8), 64'd0);
        check("done8_busy_low", 64'(bus8.BUSY), 64'd0);
        if (q8.size() == 0) begin
          total_cnt++;
          $display("FAIL done8_unexpected: got DONE with bcd 0x%0h, expected no DONE", bus8.BCD);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("bcd8", 64'(bus8.BCD), 64'(e.bcd));
          check("ovf8", 64'(bus8.OVF), 64'(e.ovf));
          check("done8_cycle", 64'(cyc), 64'(e.done_cyc));
        end
        done8++;
      end
      if (bus4.DONE) begin
        check("done4_width", 64'(prev_done4), 64'd0);
        if (q4.size() == 0) begin
          total_cnt++;
          $display("FAIL done4_unexpected: got DONE with bcd 0x%0h, expected no DONE", bus4.BCD);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("bcd4", 64'(bus4.BCD), 64'(e.bcd[15:0]));
          check("ovf4", 64'(bus4.OVF), 64'(e.ovf));
          check("done4_cycle", 64'(cyc), 64'(e.done_cyc));
        end
        done4++;
      end
    end
    prev_done8 = bus8.DONE;
    prev_done4 = bus4.DONE;
  end

  // Pulse START for one cycle; records the accepting edge and queues the expectation.
  task automatic start8(input logic [25:0] v, input logic [31:0] exp, input logic ovf,
                        output int acc);
    bus8.BIN   = v;
    bus8.START = 1'b1;
    @(posedge clk);
    #1;
    acc        = cyc;
    bus8.START = 1'b0;
    q8.push_back('{bcd: exp, ovf: ovf, done_cyc: acc + 27});
  endtask

  task automatic start4(input logic [25:0] v, input logic [31:0] exp, input logic ovf);
    bus4.BIN   = v;
    bus4.START = 1'b1;
    @(posedge clk);
    #1;
    bus4.START = 1'b0;
    q4.push_back('{bcd: exp, ovf: ovf, done_cyc: cyc + 27});
  endtask

  task automatic wait8(input int target);
    int n = 0;
    while (done8 < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done8 < target) begin
      total_cnt++;
      $display("FAIL wait8_timeout: got %0d DONEs, expected %0d", done8, target);
    end
  endtask

  task automatic wait4(input int target);
    int n = 0;
    while (done4 < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done4 < target) begin
      total_cnt++;
      $display("FAIL wait4_timeout: got %0d DONEs, expected %0d", done4, target);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          n;
    logic [25:0] vals  [6] = '{26'd0, 26'd1, 26'd9, 26'd10, 26'd99, 26'd100};
    logic [31:0] plain [6] = '{32'h0, 32'h1, 32'h9, 32'h10, 32'h99, 32'h100};
    logic [31:0] lzb   [6] = '{32'hFFFFFFF0, 32'hFFFFFFF1, 32'hFFFFFFF9,
                               32'hFFFFFF10, 32'hFFFFFF99, 32'hFFFFF100};

    bus8.START = 1'b0;
    bus8.BIN   = '0;
    bus4.START = 1'b0;
    bus4.BIN   = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state after 10 idle cycles
    repeat (10) @(posedge clk);
    #1;
    check("rst_bcd",  64'(bus8.BCD),  64'd0);
    check("rst_busy", 64'(bus8.BUSY), 64'd0);
    check("rst_done", 64'(bus8.DONE), 64'd0);
    check("rst_ovf",  64'(bus8.OVF),  64'd0);

    // Basic conversion with latency
    start8(26'd12345678, 32'h12345678, 1'b0, acc);
    check("busy_after_start", 64'(bus8.BUSY), 64'd1);
    wait8(1);
    check("done_cleared", 64'(bus8.DONE), 64'd0);
    check("busy_idle",    64'(bus8.BUSY), 64'd0);

    // Maximum 26-bit value
    start8(26'd67108863, 32'h67108863, 1'b0, acc);
    wait8(2);

    // 4-digit instance: overflow, then a fitting value clears OVF
    start4(26'd12345, 32'h2345, 1'b1);
    wait4(1);
    start4(26'd99, sel(32'h0099, 32'hFF99), 1'b0);
    wait4(2);

    // START while busy is ignored; BIN changes while busy have no effect
    n = done8;
    start8(26'd4321, sel(32'h00004321, 32'hFFFF4321), 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    bus8.BIN   = 26'd999;
    bus8.START = 1'b1;
    @(posedge clk);
    #1;
    bus8.START = 1'b0;
    wait8(n + 1);
    repeat (30) @(posedge clk);
    #1;
    check("single_done", 64'(done8), 64'(n + 1));
    check("bcd_hold", 64'(bus8.BCD), 64'(sel(32'h00004321, 32'hFFFF4321)));

    // Reset mid-conversion aborts without DONE
    n          = done8;
    bus8.BIN   = 26'd55555;
    bus8.START = 1'b1;
    @(posedge clk);
    #1;
    bus8.START = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(bus8.BUSY), 64'd0);
    check("abort_bcd",  64'(bus8.BCD),  64'd0);
    check("abort_done", 64'(bus8.DONE), 64'd0);
    repeat (35) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done8), 64'(n));

    // START held high: back-to-back conversions every 28 cycles
    n          = done8;
    bus8.BIN   = vals[0];
    bus8.START = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    q8.push_back('{bcd: sel(plain[0], lzb[0]), ovf: 1'b0, done_cyc: acc + 27});
    for (int k = 1; k < 6; k++) begin
      bus8.BIN = vals[k];
      repeat (28) @(posedge clk);
      #1;
      q8.push_back('{bcd: sel(plain[k], lzb[k]), ovf: 1'b0, done_cyc: acc + 28 * k + 27});
    end
    bus8.START = 1'b0;
    wait8(n + 6);

    // Blanking vectors
    start8(26'd405, sel(32'h00000405, 32'hFFFFF405), 1'b0, acc);
    wait8(n + 7);
    start8(26'd0, sel(32'h00000000, 32'hFFFFFFF0), 1'b0, acc);
    wait8(n + 8);

    repeat (5) @(posedge clk);
    #1;
    check("q8_empty", 64'(q8.size()), 64'd0);
    check("q4_empty", 64'(q4.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
